// File: rtl/tx_slot_scheduler_if.sv
// tx_slot_if: requester/modulator signal bundle of tx_slot_scheduler.
// master drives the requests and strobes; slave is the scheduler.
interface tx_slot_if #(
    parameter int SLOTS = 8
);
    localparam int TW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    logic             next_symbol_strobe;
    logic             slot_mask_wr;
    logic [SLOTS-1:0] slot_mask_data;
    logic             burst_pending;
    logic             bit_valid;
    logic             bit_in;
    logic             underrun_clear;
    logic             bit_req;
    logic             current_symbol;
    logic             fire_burst;
    logic             tx_active;
    logic [TW-1:0]    timeslot;
    logic [21:0]      frame_number;
    logic             underrun;

    modport master (
        output next_symbol_strobe, slot_mask_wr, slot_mask_data, burst_pending,
               bit_valid, bit_in, underrun_clear,
        input  bit_req, current_symbol, fire_burst, tx_active, timeslot,
               frame_number, underrun
    );

    modport slave (
        input  next_symbol_strobe, slot_mask_wr, slot_mask_data, burst_pending,
               bit_valid, bit_in, underrun_clear,
        output bit_req, current_symbol, fire_burst, tx_active, timeslot,
               frame_number, underrun
    );
endinterface

// File: rtl/tx_slot_scheduler.sv
// tx_slot_scheduler: TDMA timeslot burst scheduler feeding a symbol-strobed modulator.
// Define TX_SCHED_FRAME_COUNT_EN to build the frame counter; otherwise frame_number is tied to 0.
module tx_slot_scheduler #(
    parameter int SYMBOLS_PER_SLOT = 156,
    parameter int BURST_BITS       = 148,
    parameter int SLOTS            = 8
) (
    input logic      clock,
    input logic      reset_n,
    tx_slot_if.slave bus
);
    localparam int PW = (SYMBOLS_PER_SLOT > 1) ? $clog2(SYMBOLS_PER_SLOT) : 1;
    localparam int TW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CW = $clog2(BURST_BITS + 1);

    typedef enum logic [1:0] {IDLE, SEND, GUARD} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    sym_pos_q, sym_pos_d;
    logic [TW-1:0]    timeslot_q, timeslot_d, slot_next;
    logic [SLOTS-1:0] mask_q, mask_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             strobe_prev_q;
    logic             bit_req_q, bit_req_d;
    logic             fire_q, fire_d;
    logic             tx_active_q, tx_active_d;
    logic             current_symbol_q, current_symbol_d;
    logic             underrun_q, underrun_d;
    logic             stb, boundary, launch, missing;

    always_comb begin
        stb = bus.next_symbol_strobe & ~strobe_prev_q;
        boundary = stb && (sym_pos_q == PW'(SYMBOLS_PER_SLOT - 1));
        slot_next = (timeslot_q == TW'(SLOTS - 1)) ? '0 : timeslot_q + TW'(1);
        // mask_q still holds the pre-write mask when a write lands on the boundary
        launch = boundary && mask_q[slot_next] && bus.burst_pending;
        sym_pos_d = boundary ? '0 : (stb ? sym_pos_q + PW'(1) : sym_pos_q);
        timeslot_d = boundary ? slot_next : timeslot_q;
        mask_d = bus.slot_mask_wr ? bus.slot_mask_data : mask_q;
        state_d = state_q;
        cnt_d = cnt_q;
        bit_req_d = 1'b0;
        fire_d = 1'b0;
        tx_active_d = tx_active_q;
        current_symbol_d = current_symbol_q;
        missing = 1'b0;
        case (state_q)
            SEND: if (stb) begin
                bit_req_d = 1'b1;
                current_symbol_d = bus.bit_valid ? bus.bit_in : 1'b1;
                missing = ~bus.bit_valid;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(BURST_BITS - 1)) begin
                    state_d = GUARD;
                    tx_active_d = 1'b0;
                end
            end
            default: if (stb) begin
                current_symbol_d = 1'b1;
                if (boundary) begin
                    state_d = launch ? SEND : IDLE;
                    fire_d = launch;
                    tx_active_d = launch;
                    cnt_d = '0;
                end
            end
        endcase
        underrun_d = missing | (underrun_q & ~bus.underrun_clear);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sym_pos_q <= '0;
            timeslot_q <= '0;
            mask_q <= '0;
            cnt_q <= '0;
            strobe_prev_q <= 1'b0;
            bit_req_q <= 1'b0;
            fire_q <= 1'b0;
            tx_active_q <= 1'b0;
            current_symbol_q <= 1'b1;
            underrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sym_pos_q <= sym_pos_d;
            timeslot_q <= timeslot_d;
            mask_q <= mask_d;
            cnt_q <= cnt_d;
            strobe_prev_q <= bus.next_symbol_strobe;
            bit_req_q <= bit_req_d;
            fire_q <= fire_d;
            tx_active_q <= tx_active_d;
            current_symbol_q <= current_symbol_d;
            underrun_q <= underrun_d;
        end
    end

`ifdef TX_SCHED_FRAME_COUNT_EN
    logic [21:0] frame_q, frame_d;

    always_comb begin
        frame_d = frame_q;
        if (boundary && slot_next == '0)
            frame_d = (frame_q == 22'd2715647) ? '0 : frame_q + 22'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            frame_q <= '0;
        else
            frame_q <= frame_d;
    end

    assign bus.frame_number = frame_q;
`else
    assign bus.frame_number = '0;
`endif

    assign bus.bit_req        = bit_req_q;
    assign bus.fire_burst     = fire_q;
    assign bus.tx_active      = tx_active_q;
    assign bus.current_symbol = current_symbol_q;
    assign bus.timeslot       = timeslot_q;
    assign bus.underrun       = underrun_q;
endmodule

// File: tb/tb_tx_slot_scheduler.sv
// tb_tx_slot_scheduler: table-driven slot scenarios, directed corner sequences and
// randomized strobes, all checked cycle by cycle against a strobe-index reference model.
module tb_tx_slot_scheduler;
    localparam int SPS   = 156;
    localparam int BB    = 148;
    localparam int SLOTS = 8;
    localparam int FRAME = SPS * SLOTS;
`ifdef TX_SCHED_FRAME_COUNT_EN
    localparam bit FRAME_EN = 1'b1;
`else
    localparam bit FRAME_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    tx_slot_if #(.SLOTS(SLOTS)) bus ();

    tx_slot_scheduler #(
        .SYMBOLS_PER_SLOT(SPS),
        .BURST_BITS(BB),
        .SLOTS(SLOTS)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] mask;
        bit         pend;
        int         drop_at;
        bit         wr_zero;
        int         fires;
        int         reqs;
        bit         und;
    } vec_t;

    vec_t vt [7];
    int checks = 0;
    int errors = 0;
    // reference model: n strobes seen since reset, base = strobe index that launched the last burst
    int n, base, obs_fire, obs_req;
    logic [7:0] m_mask;
    bit m_und, m_prev, e_req, e_fire, e_tx, e_sym;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at strobe %0d: got %0h expected %0h", name, n, act, exp);
        end
    endtask

    task automatic model_reset();
        n = 0;
        base = -1000000;
        m_mask = 8'h00;
        m_und = 1'b0;
        m_prev = 1'b0;
        e_req = 1'b0;
        e_fire = 1'b0;
        e_tx = 1'b0;
        e_sym = 1'b1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_bit_req"}, 32'(bus.bit_req), 0);
        chk({tag, "_fire"}, 32'(bus.fire_burst), 0);
        chk({tag, "_tx_active"}, 32'(bus.tx_active), 0);
        chk({tag, "_symbol"}, 32'(bus.current_symbol), 1);
        chk({tag, "_timeslot"}, 32'(bus.timeslot), 0);
        chk({tag, "_frame"}, 32'(bus.frame_number), 0);
        chk({tag, "_underrun"}, 32'(bus.underrun), 0);
    endtask

    task automatic step(input bit stb, input bit wr, input logic [7:0] d, input bit pend,
                        input bit val, input bit bin, input bit clr);
        bit set;
        int off;
        bus.next_symbol_strobe = stb;
        bus.slot_mask_wr = wr;
        bus.slot_mask_data = d;
        bus.burst_pending = pend;
        bus.bit_valid = val;
        bus.bit_in = bin;
        bus.underrun_clear = clr;
        @(posedge clock);
        #1;
        set = 1'b0;
        e_req = 1'b0;
        e_fire = 1'b0;
        if (stb && !m_prev) begin
            off = n - base;
            if (off >= 1 && off <= BB) begin
                e_req = 1'b1;
                e_sym = val ? bin : 1'b1;
                set = !val;
                e_tx = off < BB;
            end else begin
                e_sym = 1'b1;
                e_tx = 1'b0;
            end
            if (n % SPS == SPS - 1 && m_mask[((n + 1) / SPS) % SLOTS] && pend) begin
                base = n;
                e_fire = 1'b1;
                e_tx = 1'b1;
            end
            n++;
        end
        m_prev = stb;
        m_und = set | (m_und & !clr);
        if (wr) m_mask = d;
        obs_fire += int'(bus.fire_burst);
        obs_req += int'(bus.bit_req);
        chk("bit_req", 32'(bus.bit_req), 32'(e_req));
        chk("fire_burst", 32'(bus.fire_burst), 32'(e_fire));
        chk("tx_active", 32'(bus.tx_active), 32'(e_tx));
        chk("current_symbol", 32'(bus.current_symbol), 32'(e_sym));
        chk("timeslot", 32'(bus.timeslot), 32'((n / SPS) % SLOTS));
        chk("frame_number", 32'(bus.frame_number), FRAME_EN ? 32'((n / FRAME) % 2715648) : 32'd0);
        chk("underrun", 32'(bus.underrun), 32'(m_und));
    endtask

    task automatic sym(input bit val, input bit bin, input bit pend, input bit wr, input logic [7:0] d);
        step(1'b1, wr, d, pend, val, bin, 1'b0);
        step(1'b0, 1'b0, 8'h00, pend, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.next_symbol_strobe = 1'b0;
        bus.slot_mask_wr = 1'b0;
        bus.slot_mask_data = 8'h00;
        bus.burst_pending = 1'b0;
        bus.bit_valid = 1'b0;
        bus.bit_in = 1'b0;
        bus.underrun_clear = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk_reset_values("reset");
        model_reset();
        reset_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int hi, lo;
        bit pend, val, bin, wr;
        logic [7:0] d;
        // mask, pending, dropped strobe index, zero-mask write on first boundary, fires, bit_reqs, underrun
        vt[0] = '{8'h02, 1'b1, -1,  1'b0, 2,  296,  1'b0};
        vt[1] = '{8'h06, 1'b1, -1,  1'b0, 4,  592,  1'b0};
        vt[2] = '{8'h02, 1'b1, 165, 1'b0, 2,  296,  1'b1};
        vt[3] = '{8'h02, 1'b0, -1,  1'b0, 0,  0,    1'b0};
        vt[4] = '{8'h01, 1'b1, -1,  1'b0, 2,  148,  1'b0};
        vt[5] = '{8'h02, 1'b1, -1,  1'b1, 1,  148,  1'b0};
        vt[6] = '{8'hFF, 1'b1, -1,  1'b0, 16, 2220, 1'b0};
        obs_fire = 0;
        obs_req = 0;
        model_reset();
        do_reset();

        for (int r = 0; r < 7; r++) begin
            do_reset();
            step(1'b0, 1'b1, vt[r].mask, vt[r].pend, 1'b1, 1'b0, 1'b0);
            obs_fire = 0;
            obs_req = 0;
            for (int k = 0; k < 2 * FRAME; k++)
                sym(k != vt[r].drop_at, 1'($urandom_range(0, 1)), vt[r].pend,
                    vt[r].wr_zero && k == SPS - 1, 8'h00);
            chk("row_fires", 32'(obs_fire), 32'(vt[r].fires));
            chk("row_bit_reqs", 32'(obs_req), 32'(vt[r].reqs));
            chk("row_underrun", 32'(bus.underrun), 32'(vt[r].und));
            if (vt[r].und) begin
                step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
                chk("underrun_cleared", 32'(bus.underrun), 0);
            end
        end

        // boundary strobe held high for three clocks counts once
        do_reset();
        step(1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < SPS - 1; k++) sym(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        obs_fire = 0;
        repeat (3) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("held_strobe_fires", 32'(obs_fire), 1);
        chk("held_strobe_timeslot", 32'(bus.timeslot), 1);

        // asynchronous reset at payload symbol 50 aborts the burst
        do_reset();
        step(1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < SPS + 50; k++) sym(1'b1, 1'(k), 1'b1, 1'b0, 8'h00);
        chk("pre_reset_tx_active", 32'(bus.tx_active), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_values("async_reset");
        bus.next_symbol_strobe = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk_reset_values("held_reset");
        bus.next_symbol_strobe = 1'b0;
        model_reset();
        reset_n = 1'b1;
        step(1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0);
        obs_fire = 0;
        obs_req = 0;
        for (int k = 0; k < SPS - 1; k++) sym(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("no_req_after_reset", 32'(obs_req), 0);
        sym(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("fire_after_reset", 32'(obs_fire), 1);

        // three full frames of strobes
        do_reset();
        for (int k = 0; k < 3 * FRAME; k++) sym(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("frame_after_three", 32'(bus.frame_number), FRAME_EN ? 32'd3 : 32'd0);
        chk("timeslot_after_three", 32'(bus.timeslot), 0);

        // randomized strobes, held strobes, mask writes, dropouts and clears
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            hi = $urandom_range(1, 3);
            lo = $urandom_range(1, 2);
            pend = $urandom_range(0, 3) != 0;
            val = $urandom_range(0, 15) != 0;
            bin = 1'($urandom_range(0, 1));
            wr = $urandom_range(0, 59) == 0;
            d = 8'($urandom);
            for (int h = 0; h < hi; h++)
                step(1'b1, wr && h == 0, d, pend, val, bin, $urandom_range(0, 31) == 0);
            for (int l = 0; l < lo; l++)
                step(1'b0, 1'b0, 8'h00, pend, 1'b1, 1'b0, $urandom_range(0, 31) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tx_slot_scheduler.md
TX_SLOT_SCHEDULER -- requirements
Module: tx_slot_scheduler

Interface
REQ-001 Parameter SYMBOLS_PER_SLOT, default 156: symbol strobes per timeslot, including the guard period.
REQ-002 Parameter BURST_BITS, default 148: payload symbols sent per burst; SHALL be less than SYMBOLS_PER_SLOT.
REQ-003 Parameter SLOTS, default 8: timeslots per TDMA frame.
REQ-004 Port clock, input, 1: the single clock; all logic is on its rising edge.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port next_symbol_strobe, input, 1: modulator is ready for the next symbol; high for exactly one clock per symbol.
REQ-007 Port slot_mask_wr, input, 1: write strobe for the slot enable mask.
REQ-008 Port slot_mask_data, input, SLOTS: new slot enable mask; bit n enables timeslot n.
REQ-009 Port burst_pending, input, 1: the requester has a burst ready.
REQ-010 Port bit_valid, input, 1: bit_in holds a valid payload symbol.
REQ-011 Port bit_in, input, 1: next payload symbol.
REQ-012 Port underrun_clear, input, 1: clears the sticky underrun flag.
REQ-013 Port bit_req, output, 1: one-clock pop pulse to the requester.
REQ-014 Port current_symbol, output, 1: symbol presented to the modulator.
REQ-015 Port fire_burst, output, 1: one-clock burst start pulse.
REQ-016 Port tx_active, output, 1: high while a burst is being sent.
REQ-017 Port timeslot, output, clog2(SLOTS): current timeslot number.
REQ-018 Port frame_number, output, 22: current TDMA frame number.
REQ-019 Port underrun, output, 1: sticky flag, set when a payload symbol was missing.

Function
REQ-020 All outputs SHALL be registered; the response to a strobe sampled in cycle N SHALL be visible in cycle N+1.
REQ-021 Internal counter sym_pos SHALL count 0 to SYMBOLS_PER_SLOT-1, advancing on each strobe.
REQ-022 A strobe at sym_pos = SYMBOLS_PER_SLOT-1 is the slot boundary; at the boundary sym_pos SHALL wrap to 0 and timeslot SHALL advance, wrapping from SLOTS-1 to 0.
REQ-023 When timeslot wraps to 0, frame_number SHALL increment modulo 2715648.
REQ-024 The FSM SHALL have three states: IDLE, SEND and GUARD.
REQ-025 IDLE to SEND SHALL occur at a slot boundary when the incoming slot's mask bit is 1 and burst_pending is 1; fire_burst SHALL pulse for one clock and tx_active SHALL go to 1.
REQ-026 In SEND, each strobe SHALL pulse bit_req for one clock.
- If bit_valid is 1: current_symbol SHALL take bit_in.
- If bit_valid is 0: current_symbol SHALL be 1 and underrun SHALL be set.
REQ-027 After BURST_BITS SEND strobes, the FSM SHALL go to GUARD: tx_active 0, current_symbol 1, no bit_req.
REQ-028 GUARD SHALL last until the next slot boundary, which is evaluated exactly as from IDLE, so back-to-back enabled slots chain.
REQ-029 In IDLE and GUARD, current_symbol SHALL be 1.
REQ-030 slot_mask_wr SHALL update the mask in the same clock it is asserted.
- If the write coincides with a boundary strobe, the boundary decision SHALL use the old mask.
REQ-031 If underrun_clear and an underrun event coincide, underrun SHALL read 1 (set wins).
REQ-032 A slot boundary with burst_pending 0, or with a masked slot, SHALL leave the FSM in IDLE with no fire_burst.
REQ-033 Strobes SHALL never be counted twice; a strobe held high for more than one clock is out of spec and SHALL be counted once per rising transition.

Reset
REQ-034 While reset_n is 0, the block SHALL hold: FSM IDLE, sym_pos 0, timeslot 0, frame_number 0, mask 0, current_symbol 1, bit_req 0, fire_burst 0, tx_active 0, underrun 0.
REQ-035 Reset asserted mid-burst SHALL abort the burst immediately, with no further bit_req.
REQ-036 After reset_n rises, the first strobe SHALL count as sym_pos 0 of slot 0, and slot 0 SHALL NOT be scheduled.

Configuration
REQ-037 With TX_SCHED_FRAME_COUNT_EN defined, frame_number SHALL count as in REQ-023.
REQ-038 Without TX_SCHED_FRAME_COUNT_EN, frame_number SHALL be constant 0 and no frame counter logic SHALL be synthesised; all other behaviour is unchanged.

Verification
REQ-039 Mask 0x02, burst_pending 1, bit_valid 1, bit_in alternating -> fire_burst pulses once after strobe 156; 148 bit_req pulses follow; tx_active is high for 148 symbols; current_symbol follows bit_in, then 1 for 8 guard symbols.
REQ-040 Mask 0x06, burst_pending 1 -> two bursts back-to-back in slots 1 and 2; tx_active falls for exactly 8 symbols between them.
REQ-041 Same as REQ-039 with bit_valid forced 0 for the 10th payload symbol -> current_symbol is 1 for that symbol and underrun is set; underrun_clear then returns underrun to 0.
REQ-042 slot_mask_wr to 0x00 on the boundary strobe into an enabled slot -> the burst still fires; it does not fire in the following frame.
REQ-043 reset_n pulsed low at payload symbol 50 -> all outputs return to reset values asynchronously; no bit_req follows until the next scheduled boundary.
REQ-044 1248 x 3 strobes with the macro defined -> frame_number reads 3; with the macro undefined -> frame_number reads 0.
